// File: rtl/frv_common.sv
// Shared fetch-path definitions: sequencer state encoding, reset PC and
// the width of the outstanding-request counters.
package frv_common;

  typedef enum logic [1:0] {
    FS_RST   = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2
  } fs_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h8000_0000;

  // MAX_OUT is capped at 3, so two bits cover every legal count.
  localparam int MAX_OUT_LIMIT = 3;
  localparam int OUT_CTR_W     = $clog2(MAX_OUT_LIMIT + 1);

endpackage

// File: rtl/frv_fetch_outstanding_ctr.sv
// Saturating up/down counter with a load port; tracks in-flight and
// to-be-dropped memory reads. Exposes the next value for lookahead.
module frv_fetch_outstanding_ctr
  import frv_common::*;
(
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 ld,
  input  logic [OUT_CTR_W-1:0] ld_val,
  input  logic                 inc,
  input  logic                 dec,
  output logic [OUT_CTR_W-1:0] cnt,
  output logic [OUT_CTR_W-1:0] cnt_nxt
);

  localparam logic [OUT_CTR_W-1:0] CNT_MAX = '1;

  logic [OUT_CTR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld)
      cnt_d = ld_val;
    else if (inc && !dec && cnt_q != CNT_MAX)
      cnt_d = cnt_q + OUT_CTR_W'(1);
    else if (dec && !inc && cnt_q != '0)
      cnt_d = cnt_q - OUT_CTR_W'(1);
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/frv_core_fetch_sequencer.sv
// Instruction fetch sequencer: issues word reads, counts them in flight,
// and steers responses into the fetch buffer, dropping stale ones after a redirect.
module frv_core_fetch_sequencer
  import frv_common::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          MAX_OUT  = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        cf_req,
  input  logic [31:0] cf_target,
  output logic        cf_ack,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [31:0] imem_addr,
  input  logic        imem_recv,
  output logic        imem_ack,
  input  logic        imem_error,
  input  logic [31:0] imem_rdata,
  output logic        buf_flush,
  output logic        f_4byte,
  output logic        f_2byte,
  output logic        f_err,
  output logic [31:0] f_in,
  input  logic        f_ready
);

  localparam logic [OUT_CTR_W-1:0] MAX_OUT_C = OUT_CTR_W'(MAX_OUT);

  fs_state_e            state_q, state_d;
  logic [31:0]          fetch_addr_q, fetch_addr_d;
  logic                 half_first_q, half_first_d;
  logic [OUT_CTR_W-1:0] n_out, n_out_nxt_unused, n_drop, n_drop_nxt, drop_ld_val;
  logic                 active, live, grant, drop_dec;
  logic                 unused_sig;

  always_comb begin
    active    = (state_q != FS_RST);
    cf_ack    = active && cf_req;
    buf_flush = cf_ack;
    imem_req  = active && (n_out < MAX_OUT_C) && !cf_req;
    imem_addr = fetch_addr_q;
    // Stale responses and responses colliding with a redirect never wait on the buffer.
    imem_ack  = active && imem_recv && (n_drop != '0 || cf_req || f_ready);
    live      = imem_ack && (n_drop == '0) && !cf_req;
    f_4byte   = live && !half_first_q;
    f_2byte   = live && half_first_q;
    f_err     = live && imem_error;
    f_in      = live ? imem_rdata : '0;

    grant       = imem_req && imem_gnt;
    drop_dec    = imem_ack && (n_drop != '0);
    drop_ld_val = n_out - OUT_CTR_W'(imem_ack);

    fetch_addr_d = fetch_addr_q;
    half_first_d = half_first_q;
    if (cf_ack) begin
      fetch_addr_d = {cf_target[31:2], 2'b00};
      half_first_d = cf_target[1];
    end else begin
      if (grant) fetch_addr_d = fetch_addr_q + 32'd4;
      if (live)  half_first_d = 1'b0;
    end

    state_d = (active && n_drop_nxt != '0) ? FS_DRAIN : FS_RUN;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= FS_RST;
      fetch_addr_q <= {PC_RESET[31:2], 2'b00};
      half_first_q <= PC_RESET[1];
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      half_first_q <= half_first_d;
    end
  end

  frv_fetch_outstanding_ctr u_n_out (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .ld       (1'b0),
    .ld_val   ('0),
    .inc      (grant),
    .dec      (imem_ack),
    .cnt      (n_out),
    .cnt_nxt  (n_out_nxt_unused)
  );

  frv_fetch_outstanding_ctr u_n_drop (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .ld       (cf_ack),
    .ld_val   (drop_ld_val),
    .inc      (1'b0),
    .dec      (drop_dec),
    .cnt      (n_drop),
    .cnt_nxt  (n_drop_nxt)
  );

  assign unused_sig = ^{cf_target[0], n_out_nxt_unused};

endmodule

// File: tb/tb_frv_core_fetch_sequencer.sv
// Self-checking bench for the fetch sequencer: a queue-based memory/buffer
// model predicts every output cycle by cycle under directed and random stimulus.
module tb_frv_core_fetch_sequencer;

  localparam logic [31:0] PC_RST = 32'h8000_0000;
  localparam int          MAXO   = 2;

  logic        g_clk, g_resetn;
  logic        cf_req, cf_ack, imem_req, imem_gnt, imem_recv, imem_ack, imem_error;
  logic        buf_flush, f_4byte, f_2byte, f_err, f_ready;
  logic [31:0] cf_target, imem_addr, imem_rdata, f_in;

  frv_core_fetch_sequencer #(.PC_RESET(PC_RST), .MAX_OUT(MAXO)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .cf_req(cf_req), .cf_target(cf_target),
    .cf_ack(cf_ack), .imem_req(imem_req), .imem_gnt(imem_gnt), .imem_addr(imem_addr),
    .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
    .imem_rdata(imem_rdata), .buf_flush(buf_flush), .f_4byte(f_4byte),
    .f_2byte(f_2byte), .f_err(f_err), .f_in(f_in), .f_ready(f_ready)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_addr;
  bit          half, in_rst, hold_v, hold_err;
  int          tests, fails;

  function automatic logic [31:0] dfun(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    in_rst   = 1'b1;
    q.delete();
    hold_v   = 1'b0;
    hold_err = 1'b0;
    exp_addr = {PC_RST[31:2], 2'b00};
    half     = PC_RST[1];
  endtask

  // One clock: drive inputs, check predicted outputs, advance the model at the edge.
  task automatic cyc(input bit cf, input logic [31:0] tgt, input bit gnt, input bit rdy,
                     input bit want, input bit err);
    bit e_req, e_ack, e_cf, lv;
    cf_req = cf; cf_target = tgt; imem_gnt = gnt; f_ready = rdy;
    if (!hold_v && want && q.size() > 0 && !in_rst) begin
      hold_v   = 1'b1;
      hold_err = err;
    end
    imem_recv  = hold_v;
    imem_error = hold_v && hold_err;
    imem_rdata = hold_v ? dfun(q[0].addr) : $urandom;
    #1;
    e_cf  = cf && !in_rst;
    e_req = !in_rst && (q.size() < MAXO) && !cf;
    e_ack = !in_rst && hold_v && (q[0].stale || cf || rdy);
    lv    = e_ack && !q[0].stale && !cf;
    chk("imem_req",   imem_req, e_req);
    chk("cf_ack",     {cf_ack, buf_flush}, {e_cf, e_cf});
    chk("imem_addr",  imem_addr, exp_addr);
    chk("imem_ack",   imem_ack, e_ack);
    chk("push_flags", {f_4byte, f_2byte, f_err}, {lv && !half, lv && half, lv && hold_err});
    chk("f_in",       f_in, lv ? dfun(q[0].addr) : 32'h0);
    @(posedge g_clk);
    if (!g_resetn) model_reset();
    else if (in_rst) in_rst = 1'b0;
    else begin
      if (e_ack) begin
        void'(q.pop_front());
        hold_v = 1'b0;
      end
      if (e_cf) begin
        foreach (q[i]) q[i].stale = 1'b1;
        exp_addr = {tgt[31:2], 2'b00};
        half     = tgt[1];
      end else begin
        if (lv) half = 1'b0;
        if (e_req && gnt) begin
          q.push_back('{exp_addr, 1'b0});
          exp_addr = exp_addr + 32'd4;
        end
      end
    end
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() > 0; k++) cyc(0, 0, 0, 1, 1, 0);
  endtask

  initial begin
    tests = 0; fails = 0;
    g_resetn = 1'b0; cf_req = 0; cf_target = 0; imem_gnt = 0; imem_recv = 0;
    imem_error = 0; imem_rdata = 0; f_ready = 1;
    hold_v = 0; hold_err = 0; half = 0; in_rst = 0; exp_addr = 0;
    repeat (2) @(posedge g_clk);
    #1;
    model_reset();

    // Reset state, including a redirect that must be ignored.
    cyc(1, 32'h0000_1234, 1, 1, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    g_resetn = 1'b1;
    cyc(0, 0, 1, 1, 0, 0);
    chk("first_req", imem_req, 1'b1);

    // Stream with grant tied high: outstanding limit, then steady responses.
    repeat (3) cyc(0, 0, 1, 1, 0, 0);
    repeat (8) cyc(0, 0, 1, 1, 1, 0);
    drain();

    // Halfword redirect.
    cyc(1, 32'h0000_0102, 1, 1, 0, 0);
    chk("hw_addr", imem_addr, 32'h0000_0100);
    repeat (8) cyc(0, 0, 1, 1, 1, 0);
    drain();

    // Drain: two reads in flight when the redirect lands.
    repeat (2) cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 32'h0000_2000, 1, 1, 0, 0);
    repeat (6) cyc(0, 0, 1, 1, 1, 0);
    drain();

    // Backpressure: response held until the buffer has room.
    cyc(0, 0, 1, 1, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    drain();

    // Error tag on live data, then an error on a stale response.
    repeat (4) cyc(0, 0, 1, 1, 1, 1);
    drain();
    repeat (2) cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 32'h0000_3000, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 1, 1, 1, 1);
    drain();

    // Collision: redirect in the same cycle as a response.
    repeat (2) cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 32'h0000_4006, 1, 1, 1, 0);
    repeat (6) cyc(0, 0, 1, 1, 1, 0);
    drain();

    // Address wrap at the top of memory.
    cyc(1, 32'hFFFF_FFFC, 1, 1, 0, 0);
    repeat (6) cyc(0, 0, 1, 1, 1, 0);
    drain();

    // Random traffic with a mid-run reset.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        g_resetn = 1'b0;
        repeat (2) cyc(($urandom % 2) == 0, $urandom, 1, 1, 1, 0);
        g_resetn = 1'b1;
      end
      cyc(($urandom % 12) == 0, $urandom, ($urandom % 4) != 0, ($urandom % 3) != 0,
          ($urandom % 2) == 0, ($urandom % 8) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
